seq_multiplier_param: RTL and testbench



---
 rtl/seq_multiplier_param.sv | 140 ++++++++++++++
 tb/tb_seq_multiplier_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_param.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle and produces the full
// 2*WIDTH-bit product. Operands are reduced to magnitudes on accept and the
// sign is re-applied when the result is registered.
// Optional build macro: MUL_EARLY_TERM_EN finishes as soon as the remaining
// multiplier is zero (minimum one BUSY cycle). The result is the same either way.
module seq_multiplier_param #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [WIDTH-1:0]  r_mag_a;
  logic [WIDTH-1:0]  r_mag_b;
  logic              r_neg;
  logic [PW-1:0]     r_acc;
  logic [SW-1:0]     r_step;
  logic [PW-1:0]     r_result;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [WIDTH-1:0]  w_mag_a_in;
  logic [WIDTH-1:0]  w_mag_b_in;
  logic              w_accept;
  logic [PW-1:0]     w_pp;
  logic [PW-1:0]     w_pp_sh;
  logic [PW-1:0]     w_acc_sum;
  logic [WIDTH-1:0]  w_mag_b_shift;
  logic              w_last;
  logic [PW-1:0]     w_final_res;

  // Operand decode: op 01 is signed x signed, 10 is signed a x unsigned b, 00/11 unsigned.
  always_comb begin
    w_a_signed = (op == 2'b01) || (op == 2'b10);
    w_b_signed = (op == 2'b01);
    w_sign_a   = w_a_signed & a[WIDTH-1];
    w_sign_b   = w_b_signed & b[WIDTH-1];
    w_mag_a_in = w_sign_a ? WIDTH'(~a + WIDTH'(1)) : a;
    w_mag_b_in = w_sign_b ? WIDTH'(~b + WIDTH'(1)) : b;
    w_accept   = in_valid && r_in_ready && !flush;
  end

  // One iteration of the shift-add datapath and the completion condition.
  always_comb begin
    w_pp          = PW'(r_mag_a) * PW'(r_mag_b[BITS_PER_CYCLE-1:0]);
    w_pp_sh       = w_pp << (32'(r_step) * BITS_PER_CYCLE);
    w_acc_sum     = r_acc + w_pp_sh;
    w_mag_b_shift = r_mag_b >> BITS_PER_CYCLE;
`ifdef MUL_EARLY_TERM_EN
    w_last        = (w_mag_b_shift == '0) || (r_step == SW'(N - 1));
`else
    w_last        = (r_step == SW'(N - 1));
`endif
    w_final_res   = r_neg ? PW'(~w_acc_sum + PW'(1)) : w_acc_sum;
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
        S_BUSY:  if (w_last)    w_state_next = S_DONE;
        S_DONE:  if (out_ready) w_state_next = S_IDLE;
        default:                w_state_next = S_IDLE;
      endcase
    end
  end

  // State register with registered status outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
      r_busy      <= (w_state_next == S_BUSY);
    end
  end

  // Operand capture, accumulation and result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_step   <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mag_a  <= w_mag_a_in;
      r_mag_b  <= w_mag_b_in;
      r_neg    <= w_sign_a ^ w_sign_b;
      r_acc    <= '0;
      r_step   <= '0;
    end else if ((r_state == S_BUSY) && !flush) begin
      r_acc    <= w_acc_sum;
      r_mag_b  <= w_mag_b_shift;
      r_step   <= r_step + SW'(1);
      if (w_last) r_result <= w_final_res;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param: sign modes, latency, backpressure,
// flush, async reset, and a 16-bit / 4-bits-per-cycle instance.
module tb_seq_multiplier_param;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  logic        flush4;
  logic        in_valid4;
  logic        in_ready4;
  logic [1:0]  op4;
  logic [15:0] a4;
  logic [15:0] b4;
  logic        out_valid4;
  logic        out_ready4;
  logic [31:0] result4;
  logic        busy4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  seq_multiplier_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op4), .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .busy(busy4)
  );

  function automatic int lat(input int et_lat, input int full_lat);
    return ET ? et_lat : full_lat;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and return #1 after the accept edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; op = 2'b11;
  endtask

  // Count edges until out_valid; in_ready must stay low and busy high meanwhile.
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc = 0;
    bit bad = 1'b0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (!out_valid && (in_ready !== 1'b0 || busy !== 1'b1)) bad = 1'b1;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " in_ready low while busy"}, 64'(bad), 64'd0);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [63:0] exp, input int exp_lat);
    start_op(o, av, bv);
    wait_done(tag, exp_lat);
    chk({tag, " result"}, result, exp);
    finish_op(tag);
  endtask

  initial begin
    bit bad;
    int cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; op4 = 2'b00; a4 = '0; b4 = '0;
    #22;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset result4", 64'(result4), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op("uu max",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    do_op("ss -1*-1",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, lat(1, 32));
    do_op("ss min*min",  2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32);
    do_op("ss min*1",    2'b01, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, lat(1, 32));
    do_op("su -1*max",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 32);
    do_op("op11 as uu",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    do_op("ss 7*-6",     2'b01, 32'h0000_0007, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6, lat(3, 32));
    do_op("uu 5*3",      2'b00, 32'h0000_0005, 32'h0000_0003, 64'd15, lat(2, 32));
    do_op("uu b=0",      2'b00, 32'h0000_1234, 32'h0000_0000, 64'd0, lat(1, 32));

    // Backpressure: result holds in DONE and a new in_valid is ignored.
    start_op(2'b00, 32'd3, 32'd4);
    wait_done("bp", lat(3, 32));
    bad = 1'b0;
    in_valid = 1'b1; a = 32'd9; b = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'd12) bad = 1'b1;
    end
    chk("bp hold stable", 64'(bad), 64'd0);
    chk("bp result", result, 64'd12);
    in_valid = 1'b0;
    finish_op("bp");
    chk("bp out_valid dropped", 64'(out_valid), 64'd0);

    // Flush on the tenth BUSY edge: back to IDLE, result keeps previous value.
    start_op(2'b00, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush result kept", result, 64'd12);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("flush no out_valid", 64'(bad), 64'd0);

    // Flush with in_valid in IDLE: operands are not taken.
    flush = 1'b1; in_valid = 1'b1; a = 32'd2; b = 32'd2; op = 2'b00;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush idle in_ready", 64'(in_ready), 64'd1);
    chk("flush idle busy", 64'(busy), 64'd0);

    // Async reset mid-BUSY takes effect without a clock edge.
    start_op(2'b00, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst result", result, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_op("after rst 7*6", 2'b00, 32'd7, 32'd6, 64'd42, lat(3, 32));

    // 16-bit instance, 4 bits per cycle.
    op4 = 2'b00; a4 = 16'h1234; b4 = 16'h5678; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bpc4 latency", 64'(cyc), 64'd4);
    chk("bpc4 result", 64'(result4), 64'h0626_0060);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("bpc4 in_ready", 64'(in_ready4), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
